fifo_burst_reader: RTL and testbench

// - Read-side drain controller for the async FIFO. Runs in the FIFO read clock domain.
// - On a start command it pops exactly burst_len words from the FIFO read port.
// - It absorbs the 1-cycle registered read latency of the dual-port memory.
// - Words are presented in order on a valid/ready stream through a 2-entry skid buffer, so nothing is lost under backpressure.
//

---
 rtl/fifo_burst_reader_if.sv | 27 ++
 rtl/fifo_burst_reader.sv | 169 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of
// fifo_burst_reader.
//   master: the burst reader (pops the FIFO, drives the stream)
//   slave : the surroundings (FIFO read side and stream consumer)
interface fifo_burst_reader_if #(
  parameter int d_width = 8
);
  // FIFO read port
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [d_width-1:0] fifo_rd_data;

  // Output stream
  logic               m_valid;
  logic               m_ready;
  logic [d_width-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side drain controller for the async FIFO.
// This block runs in the FIFO read clock domain.
//
// When start arrives in IDLE, the controller pops exactly burst_len words
// from the FIFO. Each popped word arrives one cycle after fifo_rd_en,
// because the FIFO memory has a registered read. The word is captured into a
// 2-entry skid buffer. From there, words are presented in order on a
// valid/ready stream.
//
// A pop is issued only when the word it returns is guaranteed a free slot.
// This means backpressure can never overflow the skid buffer. With m_ready
// held high, the stream still sustains one word per clock.
//
// Optional feature, enabled by defining FIFO_RD_STATS_EN:
//   pop_count: a 16-bit wrapping count of every fifo_rd_en. It is cleared
//   only by reset.
module fifo_burst_reader #(
  parameter int d_width = 8,
  parameter int len_w   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [len_w-1:0] burst_len,
  output logic             busy,
  output logic             done,
`ifdef FIFO_RD_STATS_EN
  output logic [15:0]      pop_count,
`endif
  fifo_burst_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } state_t;

  state_t             state;
  logic [len_w-1:0]   len_q;
  logic [len_w-1:0]   issued;
  logic [len_w-1:0]   accepted;

  // The skid buffer is a 2-entry ring.
  // occ counts the words held in it.
  // inflight marks a FIFO read whose data returns this cycle.
  logic [d_width-1:0] skid [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         occ;
  logic               inflight;

  logic               pop;
  logic               issue;
  logic [2:0]         occ_after;

  assign pop = (occ != 2'd0) && bus.m_ready;

  // occ_after is the occupancy at the end of this cycle.
  // It never underflows: a pop requires occ >= 1.
  assign occ_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Pop the FIFO only when the returning word will find a free skid slot.
  always_comb begin
    // NOTE: assign a default first so that no path through the block
    // leaves issue unassigned; otherwise a latch would be inferred.
    issue = 1'b0;
    if ((state == S_BURST) && !bus.fifo_empty && (issued < len_q) &&
        (occ_after < 3'd2)) begin
      issue = 1'b1;
    end
  end

  assign bus.fifo_rd_en = issue;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = skid[rd_ptr];

  // Burst control FSM: state, latched length, counters and registered status.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments here, so that every register
    // samples the values that were present before the clock edge.
    if (reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= burst_len;
            issued   <= '0;
            accepted <= '0;
            busy     <= 1'b1;
            if (burst_len != '0) begin
              state <= S_BURST;
            end else begin
              // A zero-length request completes at once, with no FIFO reads.
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (issue) begin
            issued <= issued + len_w'(1);
          end
          if (pop) begin
            accepted <= accepted + len_w'(1);
            if (accepted == len_q - len_w'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Skid buffer: the returning read data goes to the tail; the stream
  // releases words from the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: both entries are cleared so that m_data reads zero out of
      // reset. On reset, any buffered word or word in flight is discarded.
      skid[0]  <= '0;
      skid[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        skid[wr_ptr] <= bus.fifo_rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_after[1:0];
    end
  end

`ifdef FIFO_RD_STATS_EN
  // Lifetime pop statistics.
  // The count wraps naturally and is kept across bursts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_count <= '0;
    end else if (issue) begin
      pop_count <= pop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed testbench for fifo_burst_reader.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. The FIFO is modelled as a word array with a registered read.
// The pop_count case is compiled only when FIFO_RD_STATS_EN is defined.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   pop_count;
`endif

  fifo_burst_reader_if #(.d_width(DW)) bus ();

  fifo_burst_reader #(
    .d_width(DW),
    .len_w  (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .burst_len(burst_len),
    .busy     (busy),
    .done     (done),
`ifdef FIFO_RD_STATS_EN
    .pop_count(pop_count),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: the word array has a registered read port.
  // stall_empty forces the empty flag high.
  logic [DW-1:0] fmem [256];
  int            f_wr        = 0;
  int            f_rd        = 0;
  logic          stall_empty = 1'b0;

  assign bus.fifo_empty = (f_rd == f_wr) || stall_empty;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= fmem[f_rd % 256];
      f_rd             <= f_rd + 1;
    end
  end

  // Stream monitor: logs accepted words, pops and done pulses.
  logic [DW-1:0] out_q [$];
  int            rd_cnt   = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) out_q.push_back(bus.m_data);
    if (bus.fifo_rd_en) rd_cnt++;
    if (done) done_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic load(input logic [DW-1:0] v);
    fmem[f_wr % 256] = v;
    f_wr++;
  endtask

  // Pulse start for one cycle. On return, the time is cycle 1 + 1 ns,
  // where cycle 1 is the first cycle after start was sampled.
  task automatic start_burst(input logic [LW-1:0] len);
    @(posedge clk); #1;
    start     = 1'b1;
    burst_len = len;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Wait (with a bound) for the done pulse.
  // Then step one cycle and confirm that busy has dropped.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  // Compare the words accepted since index base against first, first+1, ...
  task automatic check_words(input string tag, input int base, input logic [DW-1:0] first,
                             input int n);
    logic [DW-1:0] exp;
    check({tag, "_word_count"}, 32'(out_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      exp = first + DW'(i);
      if (base + i < out_q.size())
        check($sformatf("%s_word%0d", tag, i), 32'(out_q[base + i]), 32'(exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            b, r0, d0, n, hs, stall_rd, stall_bad;
    logic [7:0]    rd_m, vld_m, dn_m, bsy_m;

    bus.m_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    32'(busy),           32'd0);
    check("rst_done",    32'(done),           32'd0);
    check("rst_rd_en",   32'(bus.fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid),    32'd0);
    check("rst_m_data",  32'(bus.m_data),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 1: len=4 with free flow. Record the cycle-by-cycle pattern.
    for (int i = 0; i < 4; i++) load(DW'(8'hA1 + i));
    b = out_q.size();
    start_burst(4);
    rd_m = '0; vld_m = '0; dn_m = '0; bsy_m = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_m[c]  = bus.fifo_rd_en;
      vld_m[c] = bus.m_valid;
      dn_m[c]  = done;
      bsy_m[c] = busy;
    end
    check("t1_rd_en_cycles",   32'(rd_m),  32'h0F);
    check("t1_m_valid_cycles", 32'(vld_m), 32'h3C);
    check("t1_done_cycles",    32'(dn_m),  32'h40);
    check("t1_busy_cycles",    32'(bsy_m), 32'h7F);
    check_words("t1", b, 8'hA1, 4);

    // Test 2: len=6, with the consumer stalled for 5 clocks after the
    // first word.
    for (int i = 0; i < 6; i++) load(DW'(8'hB1 + i));
    b = out_q.size();
    start_burst(6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.m_valid && bus.m_ready) && n < 20);
    check("t2_first_handshake", 32'(bus.m_valid && bus.m_ready), 32'd1);
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    stall_rd = 0; stall_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      stall_rd += int'(bus.fifo_rd_en);
      if (!bus.m_valid || bus.m_data !== 8'hB2) stall_bad++;
    end
    check("t2_rd_en_while_stalled", 32'(stall_rd),  32'd0);
    check("t2_held_cycles_wrong",   32'(stall_bad), 32'd0);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_done("t2");
    check_words("t2", b, 8'hB1, 6);

    // Test 3: len=5, with the FIFO flagged empty for 3 clocks mid-burst.
    for (int i = 0; i < 5; i++) load(DW'(8'hE1 + i));
    b = out_q.size(); r0 = rd_cnt; d0 = done_cnt;
    start_burst(5);
    @(posedge clk); #1;
    stall_empty = 1'b1;
    stall_rd = 0;
    repeat (3) begin
      @(negedge clk);
      stall_rd += int'(bus.fifo_rd_en);
    end
    @(posedge clk); #1;
    stall_empty = 1'b0;
    check("t3_rd_en_while_empty", 32'(stall_rd), 32'd0);
    wait_done("t3");
    check_words("t3", b, 8'hE1, 5);
    check("t3_pop_total",  32'(rd_cnt - r0),   32'd5);
    check("t3_done_count", 32'(done_cnt - d0), 32'd1);

    // Test 4a: a zero-length request completes on the next clock, with
    // no FIFO reads.
    r0 = rd_cnt; d0 = done_cnt;
    start_burst(0);
    @(negedge clk);
    check("t4_len0_done", 32'(done), 32'd1);
    check("t4_len0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4_len0_done_clear", 32'(done), 32'd0);
    check("t4_len0_busy_clear", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t4_len0_pops",       32'(rd_cnt - r0),   32'd0);
    check("t4_len0_done_count", 32'(done_cnt - d0), 32'd1);

    // Test 4b: a start asserted during a len=3 burst is ignored.
    for (int i = 0; i < 3; i++) load(DW'(8'hC1 + i));
    b = out_q.size(); r0 = rd_cnt; d0 = done_cnt;
    start_burst(3);
    @(posedge clk); #1;
    start     = 1'b1;
    burst_len = 4'd7;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done("t4b");
    check_words("t4b", b, 8'hC1, 3);
    check("t4b_pop_total",  32'(rd_cnt - r0),   32'd3);
    check("t4b_done_count", 32'(done_cnt - d0), 32'd1);

    // Test 5: reset after the 2nd handshake of a len=4 burst.
    for (int i = 0; i < 4; i++) load(DW'(8'hD1 + i));
    start_burst(4);
    hs = 0; n = 0;
    while (hs < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.m_valid && bus.m_ready) hs++;
    end
    check("t5_two_handshakes", 32'(hs), 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("t5_rst_busy",    32'(busy),        32'd0);
    check("t5_rst_done",    32'(done),        32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) load(DW'(8'h51 + i));
    b = out_q.size(); d0 = done_cnt;
    start_burst(3);
    wait_done("t5_after");
    check_words("t5_after", b, 8'h51, 3);
    check("t5_after_done_count", 32'(done_cnt - d0), 32'd1);

`ifdef FIFO_RD_STATS_EN
    // Test 6: pop statistics accumulate across bursts.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_pop_count_reset", 32'(pop_count), 32'd0);
    for (int i = 0; i < 4; i++) load(DW'(8'h71 + i));
    start_burst(4);
    wait_done("t6_a");
    for (int i = 0; i < 3; i++) load(DW'(8'h81 + i));
    start_burst(3);
    wait_done("t6_b");
    check("t6_pop_count", 32'(pop_count), 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
